// File: rtl/regfile_mp.sv
// Multi-port register file with prioritised writes and a pending-load scoreboard.
// Optional same-cycle write-to-read bypass under REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*ADDR_W-1:0] waddr,
  input  logic [NWRITE*DATA_W-1:0] wdata,
  input  logic [NREAD-1:0]         re,
  input  logic [NREAD*ADDR_W-1:0]  raddr,
  output logic [NREAD*DATA_W-1:0]  rdata,
  input  logic                     ld_issue,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic [NREAD-1:0]         rbusy,
  output logic                     stall,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem  [NREG];
  logic [DATA_W-1:0] wval [NREG];
  logic [NREG-1:0]   wen;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   set_v;
  logic [ADDR_W:0]   dec;
  logic [ADDR_W:0]   inc;

  // Later ports overwrite earlier ones, giving higher index priority.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wen[r]  = 1'b0;
      wval[r] = '0;
    end
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < NWRITE; k++) begin
        if (we[k] && waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          wen[r]  = 1'b1;
          wval[r] = wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    set_v = '0;
    if (ld_issue && ld_addr != '0)
      set_v[ld_addr] = 1'b1;
  end

  always_comb begin
    dec = '0;
    for (int r = 0; r < NREG; r++) begin
      if (busy[r] && wen[r] && !set_v[r])
        dec = dec + (ADDR_W+1)'(1);
    end
    inc = {{ADDR_W{1'b0}}, |(set_v & ~busy)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++)
        mem[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++)
        if (wen[r])
          mem[r] <= wval[r];
    end
  end

  // A new load supersedes a completing write to the same register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= (busy & ~wen) | set_v;
      busy_cnt <= busy_cnt + inc - dec;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (re[i] && raddr[i*ADDR_W +: ADDR_W] != '0) begin
`ifdef REGFILE_BYPASS_EN
        if (wen[raddr[i*ADDR_W +: ADDR_W]])
          rdata[i*DATA_W +: DATA_W] = wval[raddr[i*ADDR_W +: ADDR_W]];
        else
          rdata[i*DATA_W +: DATA_W] = mem[raddr[i*ADDR_W +: ADDR_W]];
`else
        rdata[i*DATA_W +: DATA_W] = mem[raddr[i*ADDR_W +: ADDR_W]];
`endif
        rbusy[i] = busy[raddr[i*ADDR_W +: ADDR_W]]
                 & ~wen[raddr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign stall = |(re & rbusy);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (default 2 read / 2 write ports).
// Expected values depend on REGFILE_BYPASS_EN for same-cycle reads.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        ld_issue;
  logic [4:0]  ld_addr;
  logic [1:0]  rbusy;
  logic        stall;
  logic [5:0]  busy_cnt;

  int n_chk;
  int n_fail;

  regfile_mp dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .ld_issue (ld_issue),
    .ld_addr  (ld_addr),
    .rbusy    (rbusy),
    .stall    (stall),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we       = '0;
    waddr    = '0;
    wdata    = '0;
    re       = '0;
    raddr    = '0;
    ld_issue = 1'b0;
    ld_addr  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] same_r5;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 32; a++) begin
      re    = 2'b11;
      raddr = {5'(a), 5'(31 - a)};
      #1;
      check($sformatf("rst_rd_a%0d", a), rdata, 64'd0);
      check($sformatf("rst_busy_a%0d", a), {62'd0, rbusy}, 64'd0);
    end
    check("rst_cnt", {58'd0, busy_cnt}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // write r5 via port 0, read same cycle and next cycle
    idle();
    we[0] = 1'b1;
    waddr[4:0] = 5'd5;
    wdata[31:0] = 32'h1234_5678;
    re[0] = 1'b1;
    raddr[4:0] = 5'd5;
`ifdef REGFILE_BYPASS_EN
    same_r5 = 32'h1234_5678;
`else
    same_r5 = 32'h0;
`endif
    #1;
    check("r5_same_cycle", {32'd0, rdata[31:0]}, {32'd0, same_r5});
    step();
    we = '0;
    #1;
    check("r5_next", {32'd0, rdata[31:0]}, 64'h1234_5678);

    // port priority on r7
    idle();
    we = 2'b11;
    waddr = {5'd7, 5'd7};
    wdata = {32'h5555_FFFF, 32'hAAAA_0000};
    step();
    idle();
    re = 2'b10;
    raddr[9:5] = 5'd7;
    #1;
    check("r7_prio", {32'd0, rdata[63:32]}, 64'h5555_FFFF);

    // r0 is hardwired
    idle();
    we[1] = 1'b1;
    waddr[9:5] = 5'd0;
    wdata[63:32] = 32'hFFFF_FFFF;
    ld_issue = 1'b1;
    ld_addr = 5'd0;
    step();
    idle();
    re = 2'b11;
    #1;
    check("r0_zero", rdata, 64'd0);
    check("r0_busy", {62'd0, rbusy}, 64'd0);
    check("r0_cnt", {58'd0, busy_cnt}, 64'd0);

    // scoreboard set on r9
    idle();
    ld_issue = 1'b1;
    ld_addr = 5'd9;
    step();
    idle();
    raddr[4:0] = 5'd9;
    #1;
    check("r9_busy_re0", {62'd0, rbusy}, 64'd0);
    check("r9_stall_re0", {63'd0, stall}, 64'd0);
    re[0] = 1'b1;
    #1;
    check("r9_busy", {62'd0, rbusy}, 64'd1);
    check("r9_stall", {63'd0, stall}, 64'd1);
    check("r9_cnt", {58'd0, busy_cnt}, 64'd1);
    we[1] = 1'b1;
    waddr[9:5] = 5'd9;
    wdata[63:32] = 32'hDEAD_BEEF;
    #1;
    check("r9_fwd_busy", {62'd0, rbusy}, 64'd0);
    check("r9_fwd_stall", {63'd0, stall}, 64'd0);
    check("r9_cnt_hold", {58'd0, busy_cnt}, 64'd1);
    step();
    we = '0;
    #1;
    check("r9_cnt_clr", {58'd0, busy_cnt}, 64'd0);
    check("r9_data", {32'd0, rdata[31:0]}, 64'hDEAD_BEEF);

    // set wins over same-cycle write on r3
    idle();
    ld_issue = 1'b1;
    ld_addr = 5'd3;
    we[0] = 1'b1;
    waddr[4:0] = 5'd3;
    wdata[31:0] = 32'h0000_0011;
    step();
    idle();
    re[1] = 1'b1;
    raddr[9:5] = 5'd3;
    #1;
    check("r3_busy", {62'd0, rbusy}, 64'd2);
    check("r3_cnt", {58'd0, busy_cnt}, 64'd1);
    check("r3_data", {32'd0, rdata[63:32]}, 64'h11);

    // reload of a busy register does not count twice
    idle();
    ld_issue = 1'b1;
    ld_addr = 5'd3;
    step();
    idle();
    #1;
    check("r3_reload_cnt", {58'd0, busy_cnt}, 64'd1);

    // set r4 while clearing r3: count unchanged, r4 busy
    idle();
    ld_issue = 1'b1;
    ld_addr = 5'd4;
    we[1] = 1'b1;
    waddr[9:5] = 5'd3;
    wdata[63:32] = 32'h0000_0022;
    step();
    idle();
    re = 2'b11;
    raddr = {5'd3, 5'd4};
    #1;
    check("swap_cnt", {58'd0, busy_cnt}, 64'd1);
    check("swap_busy", {62'd0, rbusy}, 64'd1);
    check("swap_stall", {63'd0, stall}, 64'd1);

    // mid-cycle asynchronous reset
    raddr = {5'd5, 5'd4};
    #2;
    rst = 1'b0;
    #1;
    check("arst_rdata", rdata, 64'd0);
    check("arst_busy", {62'd0, rbusy}, 64'd0);
    check("arst_stall", {63'd0, stall}, 64'd0);
    check("arst_cnt", {58'd0, busy_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    #1;
    check("post_rst_r5", {32'd0, rdata[63:32]}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
